uart_arbiter: RTL and testbench

UART_ARBITER -- requirements
Module: uart_arbiter

---
 rtl/uart_ctrl_pkg.sv | 23 ++
 rtl/uart_arbiter_if.sv | 31 +++
 rtl/rr_arbiter2.sv | 37 +++
 rtl/uart_arbiter.sv | 137 +++++++++++++
 tb/tb_uart_arbiter.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART transmit arbiter and its round-robin grant logic.
package uart_ctrl_pkg;

  // Idle cycles after each send: one 8N1 frame at 115200 baud on a 50 MHz clock.
  localparam int unsigned TX_GAP_CYCLES_DEFAULT = 4340;
  localparam int GAP_CNT_W = 16;
  localparam int NUM_PORTS = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_state_t;

  // With both ports requesting the pointer decides; otherwise the lone requester wins.
  function automatic logic rr_pick(input logic [1:0] req, input logic ptr);
    if (req == 2'b11) begin
      return ptr;
    end
    return req[1];
  endfunction

endpackage

// File: rtl/uart_arbiter_if.sv
// Bundle of the two requester ports, the UART wrapper side and the RX consumer side.
interface uart_arbiter_if;
  logic       req0;
  logic [7:0] data0;
  logic       ack0;
  logic       req1;
  logic [7:0] data1;
  logic       ack1;
  logic [7:0] uart_in;
  logic       uart_send;
  logic       uart_receive;
  logic [7:0] uart_out;
  logic       uart_data_available;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_overrun;
  logic       busy;

  // Arbiter side.
  modport slave (
    input  req0, data0, req1, data1, uart_out, uart_data_available, rx_ready,
    output ack0, ack1, uart_in, uart_send, uart_receive, rx_data, rx_valid, rx_overrun, busy
  );

  // Requesters, UART wrapper and RX consumer side.
  modport master (
    output req0, data0, req1, data1, uart_out, uart_data_available, rx_ready,
    input  ack0, ack1, uart_in, uart_send, uart_receive, rx_data, rx_valid, rx_overrun, busy
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin grant: the pointer flips to the other port after every taken grant.
module rr_arbiter2
  import uart_ctrl_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       take,
  output logic       grant_valid,
  output logic       grant_idx
);

  logic pointer_reg;
  logic pointer_next;

  always_comb begin
    grant_valid = |req;
    grant_idx   = rr_pick(req, pointer_reg);
  end

  // Pointer moves even when a single requester wins without contention.
  always_comb begin
    pointer_next = pointer_reg;
    if (take && grant_valid) begin
      pointer_next = ~grant_idx;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      pointer_reg <= 1'b0;
    end else begin
      pointer_reg <= pointer_next;
    end
  end

endmodule

// File: rtl/uart_arbiter.sv
// Shares one UART wrapper between two byte sources (round-robin, paced by a frame gap)
// and buffers received bytes for a single consumer with a sticky overrun flag.
module uart_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned TX_GAP_CYCLES = TX_GAP_CYCLES_DEFAULT  // legal 1..65535
) (
  input logic         CLOCK_50,
  input logic         reset,
  uart_arbiter_if.slave bus
);

  localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'(TX_GAP_CYCLES);

  // ---------------- TX path ----------------
  logic [NUM_PORTS-1:0] req_vec;
  logic [7:0]           port_data [NUM_PORTS];
  logic [NUM_PORTS-1:0] ack_vec;

  assign req_vec      = {bus.req1, bus.req0};
  assign port_data[0] = bus.data0;
  assign port_data[1] = bus.data1;

  tx_state_t            state_reg, state_next;
  logic [GAP_CNT_W-1:0] gap_cnt_reg, gap_cnt_next;
  logic                 grant_idx_reg, grant_idx_next;
  logic [7:0]           tx_data_reg, tx_data_next;

  logic arb_valid;
  logic arb_idx;
  logic arb_take;

  rr_arbiter2 u_rr_arbiter2 (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .req        (req_vec),
    .take       (arb_take),
    .grant_valid(arb_valid),
    .grant_idx  (arb_idx)
  );

  always_comb begin
    state_next     = state_reg;
    gap_cnt_next   = gap_cnt_reg;
    grant_idx_next = grant_idx_reg;
    tx_data_next   = tx_data_reg;
    arb_take       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (arb_valid) begin
          state_next     = SEND;
          grant_idx_next = arb_idx;
          tx_data_next   = port_data[arb_idx];
          arb_take       = 1'b1;
        end
      end
      SEND: begin
        state_next   = GAP;
        gap_cnt_next = GAP_LOAD;
      end
      GAP: begin
        // Counter value 1 marks the last gap cycle, so GAP spans exactly GAP_LOAD cycles.
        if (gap_cnt_reg <= GAP_CNT_W'(1)) begin
          state_next   = IDLE;
          gap_cnt_next = '0;
        end else begin
          gap_cnt_next = gap_cnt_reg - GAP_CNT_W'(1);
        end
      end
      default: begin
        state_next   = IDLE;
        gap_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_reg     <= IDLE;
      gap_cnt_reg   <= '0;
      grant_idx_reg <= 1'b0;
      tx_data_reg   <= 8'h00;
    end else begin
      state_reg     <= state_next;
      gap_cnt_reg   <= gap_cnt_next;
      grant_idx_reg <= grant_idx_next;
      tx_data_reg   <= tx_data_next;
    end
  end

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_ack
    assign ack_vec[gi] = (state_reg == SEND) && (grant_idx_reg == 1'(gi));
  end

  assign bus.ack0      = ack_vec[0];
  assign bus.ack1      = ack_vec[1];
  assign bus.uart_send = (state_reg == SEND);
  assign bus.uart_in   = (state_reg == SEND) ? tx_data_reg : 8'h00;
  assign bus.busy      = (state_reg != IDLE);

  // ---------------- RX path ----------------
  logic       uart_receive_reg;
  logic       rx_pending_reg;
  logic [7:0] rx_data_reg;
  logic       rx_valid_reg;
  logic       rx_overrun_reg;

  // The wrapper presents the byte one cycle after its strobe, hence the pending stage.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      uart_receive_reg <= 1'b0;
      rx_pending_reg   <= 1'b0;
      rx_data_reg      <= 8'h00;
      rx_valid_reg     <= 1'b0;
      rx_overrun_reg   <= 1'b0;
    end else begin
      uart_receive_reg <= 1'b1;
      rx_pending_reg   <= bus.uart_data_available;
      if (rx_pending_reg) begin
        if (!rx_valid_reg || bus.rx_ready) begin
          rx_data_reg  <= bus.uart_out;
          rx_valid_reg <= 1'b1;
        end else begin
          rx_overrun_reg <= 1'b1;
        end
      end else if (rx_valid_reg && bus.rx_ready) begin
        rx_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.uart_receive = uart_receive_reg;
  assign bus.rx_data      = rx_data_reg;
  assign bus.rx_valid     = rx_valid_reg;
  assign bus.rx_overrun   = rx_overrun_reg;

endmodule

// File: tb/tb_uart_arbiter.sv
// Directed bench for uart_arbiter with a 4-cycle frame gap; expected values are hand-derived.
module tb_uart_arbiter;
  import uart_ctrl_pkg::*;

  logic CLOCK_50;
  logic reset;
  int   n_checks;
  int   n_fail;

  uart_arbiter_if bus ();

  uart_arbiter #(.TX_GAP_CYCLES(4)) dut (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .bus     (bus)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Step to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req0 = 1'b0;
    bus.data0 = 8'h00;
    bus.req1 = 1'b0;
    bus.data1 = 8'h00;
    bus.uart_out = 8'h00;
    bus.uart_data_available = 1'b0;
    bus.rx_ready = 1'b0;
  endtask

  // Leaves the bench in cycle 0: reset already applied, reset now low.
  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  // One line per UART transaction.
  always @(negedge CLOCK_50) begin
    if (bus.uart_send)
      $display("tx byte %02h ack0=%0b ack1=%0b", bus.uart_in, bus.ack0, bus.ack1);
    if (bus.rx_valid && bus.rx_ready)
      $display("rx byte %02h consumed", bus.rx_data);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_in;
    n_checks = 0;
    n_fail = 0;
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();

    // Reset values
    check_eq("rst ack0", bus.ack0, 0);
    check_eq("rst ack1", bus.ack1, 0);
    check_eq("rst uart_send", bus.uart_send, 0);
    check_eq("rst uart_in", bus.uart_in, 0);
    check_eq("rst uart_receive", bus.uart_receive, 0);
    check_eq("rst rx_data", bus.rx_data, 0);
    check_eq("rst rx_valid", bus.rx_valid, 0);
    check_eq("rst rx_overrun", bus.rx_overrun, 0);
    check_eq("rst busy", bus.busy, 0);

    // Single request from port 0
    do_reset();
    bus.req0 = 1'b1;
    bus.data0 = 8'hA5;
    tick();
    check_eq("A c1 uart_send", bus.uart_send, 1);
    check_eq("A c1 ack0", bus.ack0, 1);
    check_eq("A c1 ack1", bus.ack1, 0);
    check_eq("A c1 uart_in", bus.uart_in, 8'hA5);
    check_eq("A c1 busy", bus.busy, 1);
    check_eq("A c1 uart_receive", bus.uart_receive, 1);
    bus.req0 = 1'b0;
    bus.data0 = 8'h00;
    for (int c = 2; c <= 5; c++) begin
      tick();
      check_eq($sformatf("A c%0d busy", c), bus.busy, 1);
      check_eq($sformatf("A c%0d uart_send", c), bus.uart_send, 0);
      check_eq($sformatf("A c%0d uart_in", c), bus.uart_in, 0);
      check_eq($sformatf("A c%0d ack0", c), bus.ack0, 0);
    end
    tick();
    check_eq("A c6 busy", bus.busy, 0);

    // Contention: order 11, 22, 11 at cycles 1, 7, 13
    do_reset();
    bus.req0 = 1'b1;
    bus.data0 = 8'h11;
    bus.req1 = 1'b1;
    bus.data1 = 8'h22;
    for (int c = 1; c <= 13; c++) begin
      tick();
      exp_in = (c == 1 || c == 13) ? 8'h11 : (c == 7) ? 8'h22 : 8'h00;
      check_eq($sformatf("B c%0d uart_send", c), bus.uart_send, (c == 1 || c == 7 || c == 13) ? 1 : 0);
      check_eq($sformatf("B c%0d uart_in", c), bus.uart_in, exp_in);
      check_eq($sformatf("B c%0d ack0", c), bus.ack0, (c == 1 || c == 13) ? 1 : 0);
      check_eq($sformatf("B c%0d ack1", c), bus.ack1, (c == 7) ? 1 : 0);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;

    // Simultaneous send and capture, then consume
    do_reset();
    bus.req0 = 1'b1;
    bus.data0 = 8'hC3;
    bus.uart_data_available = 1'b1;
    bus.uart_out = 8'hFF;
    tick();
    check_eq("C send", bus.uart_send, 1);
    check_eq("C uart_in", bus.uart_in, 8'hC3);
    check_eq("C early rx_valid", bus.rx_valid, 0);
    bus.req0 = 1'b0;
    bus.uart_data_available = 1'b0;
    bus.uart_out = 8'h3C;
    tick();
    check_eq("C rx_valid", bus.rx_valid, 1);
    check_eq("C rx_data", bus.rx_data, 8'h3C);
    check_eq("C rx_overrun", bus.rx_overrun, 0);
    check_eq("C busy", bus.busy, 1);
    bus.rx_ready = 1'b1;
    bus.uart_out = 8'h00;
    tick();
    check_eq("C consumed rx_valid", bus.rx_valid, 0);
    bus.rx_ready = 1'b0;

    // Overrun: 3C captured, 5A dropped
    do_reset();
    bus.uart_data_available = 1'b1;
    bus.uart_out = 8'hFF;
    tick();
    bus.uart_data_available = 1'b0;
    bus.uart_out = 8'h3C;
    tick();
    check_eq("D first rx_data", bus.rx_data, 8'h3C);
    bus.uart_data_available = 1'b1;
    bus.uart_out = 8'hFF;
    tick();
    bus.uart_data_available = 1'b0;
    bus.uart_out = 8'h5A;
    tick();
    check_eq("D ovr rx_data", bus.rx_data, 8'h3C);
    check_eq("D ovr rx_valid", bus.rx_valid, 1);
    check_eq("D ovr rx_overrun", bus.rx_overrun, 1);
    bus.rx_ready = 1'b1;
    tick();
    bus.rx_ready = 1'b0;
    tick();
    check_eq("D sticky rx_overrun", bus.rx_overrun, 1);
    check_eq("D drained rx_valid", bus.rx_valid, 0);

    // Capture coincident with consume: no overrun
    do_reset();
    check_eq("E post-reset rx_overrun", bus.rx_overrun, 0);
    bus.uart_data_available = 1'b1;
    bus.uart_out = 8'hFF;
    tick();
    bus.uart_data_available = 1'b0;
    bus.uart_out = 8'h3C;
    tick();
    bus.uart_data_available = 1'b1;
    bus.uart_out = 8'hFF;
    tick();
    check_eq("E held rx_valid", bus.rx_valid, 1);
    bus.uart_data_available = 1'b0;
    bus.uart_out = 8'h5A;
    bus.rx_ready = 1'b1;
    tick();
    bus.rx_ready = 1'b0;
    check_eq("E rx_data", bus.rx_data, 8'h5A);
    check_eq("E rx_valid", bus.rx_valid, 1);
    check_eq("E rx_overrun", bus.rx_overrun, 0);

    // Reset during GAP aborts the gap
    do_reset();
    bus.req1 = 1'b1;
    bus.data1 = 8'hE7;
    tick();
    check_eq("F c1 ack1", bus.ack1, 1);
    check_eq("F c1 uart_in", bus.uart_in, 8'hE7);
    tick();
    tick();
    check_eq("F c3 busy", bus.busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("F c4 busy", bus.busy, 0);
    check_eq("F c4 ack1", bus.ack1, 0);
    check_eq("F c4 uart_send", bus.uart_send, 0);
    check_eq("F c4 uart_receive", bus.uart_receive, 0);
    tick();
    check_eq("F c5 ack1", bus.ack1, 1);
    check_eq("F c5 uart_send", bus.uart_send, 1);
    check_eq("F c5 uart_in", bus.uart_in, 8'hE7);
    check_eq("F c5 uart_receive", bus.uart_receive, 1);
    bus.req1 = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
